csr_regfile: RTL and testbench
==============================

# csr_regfile

Machine-mode CSR storage for the RV32 core: the responder for the CSR read/modify/write requests produced by the CSR execution unit. Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, the 64-bit cycle and instret counters, and the read-only ID registers. Captures trap state on exceptions and interrupts, restores it on mret, and raises the machine timer interrupt request.

## Interface
- No parameters. Register set and reset values are fixed constants in `csr_pkg`.
- `clk  in  1` — core clock.
- `rst  in  1` — reset; synchronous, active-high.
- `csrAddr  in  12` — CSR address from instruction bits [31:20].
- `csrRead  in  1` — read request, already qualified by csrOp.
- `csrWrite  in  1` — write request, already qualified by csrOp.
- `csrWdata  in  32` — new value computed by the CSR unit.
- `csrRdata  out  32` — current value at csrAddr; 0 when unsupported.
- `csrIllegal  out  1` — the access is illegal.
- `retire  in  1` — one instruction retires this cycle.
- `trapValid  in  1` — take a trap this cycle.
- `trapCause  in  32` — mcause value; bit31 set for interrupts.
- `trapPc  in  32` — PC saved to mepc.
- `trapTval  in  32` — value saved to mtval.
- `mretValid  in  1` — mret executes this cycle.
- `timerIrq  in  1` — machine timer pending, level.
- `trapVector  out  32` — {mtvec[31:2], 2'b00}.
- `mepcOut  out  32` — mret target.
- `irqPending  out  1` — mstatus.MIE & mie.MTIE & timerIrq.

## Operation
- Address map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: reads 0x40000100; writes are ignored and legal.
  - mie 0x304: only MTIE[7] is writable.
  - mtvec 0x305: bits [1:0] are forced to 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342, mtval 0x343: full 32 bits.
  - mip 0x344: MTIP[7] = timerIrq; writes are ignored.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: read/write.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: read-only shadows.
  - mvendorid, marchid, mimpid, mhartid (0xF11–0xF14): read 0.
- `csrIllegal` = (csrRead|csrWrite) & (address unsupported | (csrWrite & csrAddr[11:10]==2'b11)).
  - Illegal writes change no state.
- Counters are 64-bit.
  - mcycle increments every cycle.
  - minstret increments when `retire` is high.
  - A carry out of the low word propagates into the high word in the same cycle.
  - A CSR write to either half replaces that half, and suppresses that counter's increment for the cycle.
- Trap entry (`trapValid`):
  - mepc ← trapPc & ~3; mcause ← trapCause; mtval ← trapTval.
  - MPIE ← MIE; MIE ← 0.
- mret (`mretValid`): MIE ← MPIE; MPIE ← 1.
- Priority within one cycle: rst > trapValid > mretValid > csrWrite.
  - A CSR write that coincides with a trap or mret is dropped.
  - Counters still increment when a trap or mret occurs.
- Reset values:
  - All storage is 0, except mtvec = 0x00000000 and MPP reads 2'b11.
  - Outputs after reset: csrRdata = value at the current address; csrIllegal and irqPending = 0; trapVector = 0; mepcOut = 0.

## Timing
- The read path is combinational: csrRdata and csrIllegal are valid in the same cycle as csrAddr.
- Writes, trap capture and mret restore update on the rising clk edge and are visible the next cycle.
- A read of mcycle returns the pre-increment value of that cycle.
- Read-during-write to the same CSR returns the old value.
- irqPending, trapVector and mepcOut are combinational from registered state plus timerIrq; the updated value appears the cycle after the write.
- Reset asserted mid-trap: reset wins and no trap state is captured.
- Counter wrap: 0xFFFFFFFF_FFFFFFFF → 0.

## Structure
- `csr_pkg` holds:
  - localparams for every CSR address;
  - mstatus bit positions (MIE=3, MPIE=7) and the MTIE/MTIP position (7);
  - the MISA constant;
  - a typedef for mstatus fields.
- Sub-module `csr_counter64`: 64-bit counter with increment enable, lo/hi write enables, 32-bit write data, and 64-bit value output. Instantiated twice, once for cycle and once for instret.

## Test plan
- After reset, read 0x300, 0x305, 0xB00 → 0x00001800, 0, 0; csrIllegal = 0.
- Write 0xFFFFFFFF to mtvec, then read → 0xFFFFFFFC; trapVector = 0xFFFFFFFC.
- Write to 0xC00 → csrIllegal = 1 and the counter is unmodified. Read of 0x7C0 → csrIllegal = 1, csrRdata = 0.
- Set MIE and MTIE, raise timerIrq → irqPending = 1.
  - Next, trapValid with cause 0x80000007, pc 0x1002 → mepc = 0x1000, MIE = 0, MPIE = 1, irqPending = 0.
  - Then mretValid → MIE = 1, MPIE = 1.
- Write mcycle = 0xFFFFFFFE, mcycleh = 0 → after 2 cycles mcycleh = 1, mcycle = 0x00000000.
  - retire held for 5 cycles → minstret increases by 5.
- trapValid together with csrWrite to mscratch → trap state captured and mscratch unchanged.
  - Reset asserted in the same cycle as trapValid → all registers hold their reset values.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file:
// address map, mstatus/mie/mip bit positions and the fixed MISA value.
package csr_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID   = 12'hF12;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIMPID    = 12'hF13;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MTIE_BIT       = 7;
  localparam int unsigned MTIP_BIT       = 7;

  localparam logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored.
  function automatic logic [XLEN-1:0] mstatus_read(input mstatus_t s);
    logic [XLEN-1:0] v;
    v = '0;
    v[MSTATUS_MIE]  = s.mie;
    v[MSTATUS_MPIE] = s.mpie;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR request/response bus between the CSR execution unit (master)
// and the CSR register file (slave).
interface csr_regfile_if;
  import csr_pkg::*;

  logic [CSR_ADDR_W-1:0] csrAddr;
  logic                  csrRead;
  logic                  csrWrite;
  logic [XLEN-1:0]       csrWdata;
  logic [XLEN-1:0]       csrRdata;
  logic                  csrIllegal;

  modport master (
    output csrAddr, csrRead, csrWrite, csrWdata,
    input  csrRdata, csrIllegal
  );

  modport slave (
    input  csrAddr, csrRead, csrWrite, csrWdata,
    output csrRdata, csrIllegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with independent 32-bit half writes;
// a write to either half suppresses that cycle's increment.
module csr_counter64
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_wr_lo,
  input  logic            i_wr_hi,
  input  logic [XLEN-1:0] i_wdata,
  output logic [63:0]     o_value
);

  logic [63:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_value[31:0]  <= i_wdata;
      if (i_wr_hi) r_value[63:32] <= i_wdata;
    end else if (i_inc) begin
      r_value <= r_value + 64'd1;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read/decode, registered writes,
// trap capture, mret restore, cycle/instret counters and timer IRQ request.
module csr_regfile
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  csr_regfile_if.slave    bus,
  input  logic            retire,
  input  logic            trapValid,
  input  logic [XLEN-1:0] trapCause,
  input  logic [XLEN-1:0] trapPc,
  input  logic [XLEN-1:0] trapTval,
  input  logic            mretValid,
  input  logic            timerIrq,
  output logic [XLEN-1:0] trapVector,
  output logic [XLEN-1:0] mepcOut,
  output logic            irqPending
);

  mstatus_t        r_mstatus;
  logic            r_mtie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic [63:0]     w_cycle;
  logic [63:0]     w_instret;
  logic [XLEN-1:0] w_rdata;
  logic            w_supported;
  logic            w_illegal;
  logic            w_wr_en;

  // Read mux and address decode; unsupported addresses read as zero.
  always_comb begin
    w_rdata     = '0;
    w_supported = 1'b1;
    unique case (bus.csrAddr)
      CSR_MSTATUS:                 w_rdata = mstatus_read(r_mstatus);
      CSR_MISA:                    w_rdata = MISA_VALUE;
      CSR_MIE:                     w_rdata[MTIE_BIT] = r_mtie;
      CSR_MTVEC:                   w_rdata = r_mtvec;
      CSR_MSCRATCH:                w_rdata = r_mscratch;
      CSR_MEPC:                    w_rdata = r_mepc;
      CSR_MCAUSE:                  w_rdata = r_mcause;
      CSR_MTVAL:                   w_rdata = r_mtval;
      CSR_MIP:                     w_rdata[MTIP_BIT] = timerIrq;
      CSR_MCYCLE,   CSR_CYCLE:     w_rdata = w_cycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    w_rdata = w_cycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   w_rdata = w_instret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_instret[63:32];
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID,   CSR_MHARTID:   w_rdata = '0;
      default:                     w_supported = 1'b0;
    endcase
  end

  assign w_illegal = (bus.csrRead || bus.csrWrite) &&
                     (!w_supported || (bus.csrWrite && (bus.csrAddr[11:10] == 2'b11)));

  // Trap and mret take the cycle; a coinciding CSR write is dropped.
  assign w_wr_en = bus.csrWrite && !w_illegal && !trapValid && !mretValid;

  assign bus.csrRdata   = w_rdata;
  assign bus.csrIllegal = w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus  <= '0;
      r_mtie     <= 1'b0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (trapValid) begin
      r_mepc         <= trapPc & ~32'h3;
      r_mcause       <= trapCause;
      r_mtval        <= trapTval;
      r_mstatus.mpie <= r_mstatus.mie;
      r_mstatus.mie  <= 1'b0;
    end else if (mretValid) begin
      r_mstatus.mie  <= r_mstatus.mpie;
      r_mstatus.mpie <= 1'b1;
    end else if (w_wr_en) begin
      case (bus.csrAddr)
        CSR_MSTATUS: begin
          r_mstatus.mie  <= bus.csrWdata[MSTATUS_MIE];
          r_mstatus.mpie <= bus.csrWdata[MSTATUS_MPIE];
        end
        CSR_MIE:      r_mtie     <= bus.csrWdata[MTIE_BIT];
        CSR_MTVEC:    r_mtvec    <= bus.csrWdata & ~32'h3;
        CSR_MSCRATCH: r_mscratch <= bus.csrWdata;
        CSR_MEPC:     r_mepc     <= bus.csrWdata & ~32'h3;
        CSR_MCAUSE:   r_mcause   <= bus.csrWdata;
        CSR_MTVAL:    r_mtval    <= bus.csrWdata;
        default: ;
      endcase
    end
  end

  csr_counter64 u_cycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_wr_lo (w_wr_en && (bus.csrAddr == CSR_MCYCLE)),
    .i_wr_hi (w_wr_en && (bus.csrAddr == CSR_MCYCLEH)),
    .i_wdata (bus.csrWdata),
    .o_value (w_cycle)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (retire),
    .i_wr_lo (w_wr_en && (bus.csrAddr == CSR_MINSTRET)),
    .i_wr_hi (w_wr_en && (bus.csrAddr == CSR_MINSTRETH)),
    .i_wdata (bus.csrWdata),
    .o_value (w_instret)
  );

  assign trapVector = {r_mtvec[31:2], 2'b00};
  assign mepcOut    = r_mepc;
  assign irqPending = r_mstatus.mie && r_mtie && timerIrq;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: table of single-cycle CSR accesses
// plus hand-written counter, trap/mret and reset sequences.
module tb_csr_regfile;
  import csr_pkg::*;

  logic        clk;
  logic        rst;
  logic        retire;
  logic        trapValid;
  logic [31:0] trapCause;
  logic [31:0] trapPc;
  logic [31:0] trapTval;
  logic        mretValid;
  logic        timerIrq;
  logic [31:0] trapVector;
  logic [31:0] mepcOut;
  logic        irqPending;

  csr_regfile_if bus();

  csr_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .retire     (retire),
    .trapValid  (trapValid),
    .trapCause  (trapCause),
    .trapPc     (trapPc),
    .trapTval   (trapTval),
    .mretValid  (mretValid),
    .timerIrq   (timerIrq),
    .trapVector (trapVector),
    .mepcOut    (mepcOut),
    .irqPending (irqPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [11:0] a;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic        ck;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CSR access cycle: expectation queued at drive, checked at the falling edge.
  task automatic csr_op(input string nm, input logic [11:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic ck, input logic [31:0] er,
                        input logic ei);
    vec_t e;
    bus.csrAddr  = a;
    bus.csrRead  = rd;
    bus.csrWrite = wr;
    bus.csrWdata = wd;
    sb.push_back('{nm, a, rd, wr, wd, ck, er, ei});
    @(negedge clk);
    e = sb.pop_front();
    if (e.ck) chk({e.nm, ".rdata"}, bus.csrRdata, e.er);
    chk({e.nm, ".illegal"}, 32'(bus.csrIllegal), 32'(e.ei));
    step();
    bus.csrRead  = 1'b0;
    bus.csrWrite = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] er);
    csr_op(nm, a, 1'b1, 1'b0, 32'h0, 1'b1, er, 1'b0);
  endtask

  task automatic wr(input string nm, input logic [11:0] a, input logic [31:0] wd);
    csr_op(nm, a, 1'b0, 1'b1, wd, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic void t(input string nm, input logic [11:0] a, input logic r, input logic w,
                            input logic [31:0] wd, input logic ck, input logic [31:0] er,
                            input logic ei);
    tbl.push_back('{nm, a, r, w, wd, ck, er, ei});
  endfunction

  initial begin
    rst = 1'b1; retire = 1'b0; trapValid = 1'b0; mretValid = 1'b0; timerIrq = 1'b0;
    trapCause = '0; trapPc = '0; trapTval = '0;
    bus.csrAddr = '0; bus.csrRead = 1'b0; bus.csrWrite = 1'b0; bus.csrWdata = '0;

    //   name            addr    rd wr  wdata         chk rdata         ill
    t("misa.rd",       12'h301, 1, 0, 32'h0,        1, 32'h4000_0100, 0);
    t("misa.wr",       12'h301, 1, 1, 32'h1234_5678, 1, 32'h4000_0100, 0);
    t("misa.rd2",      12'h301, 1, 0, 32'h0,        1, 32'h4000_0100, 0);
    t("mtvec.wr",      12'h305, 1, 1, 32'hFFFF_FFFF, 1, 32'h0,         0);
    t("mtvec.rd",      12'h305, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0);
    t("mscratch.wr",   12'h340, 0, 1, 32'hA5A5_5A5A, 0, 32'h0,         0);
    t("mscratch.rd",   12'h340, 1, 0, 32'h0,        1, 32'hA5A5_5A5A, 0);
    t("mip.wr",        12'h344, 1, 1, 32'hFFFF_FFFF, 1, 32'h0,         0);
    t("mip.rd",        12'h344, 1, 0, 32'h0,        1, 32'h0,         0);
    t("mstatus.wr1",   12'h300, 1, 1, 32'hFFFF_FFFF, 1, 32'h0000_1800, 0);
    t("mstatus.rd1",   12'h300, 1, 0, 32'h0,        1, 32'h0000_1888, 0);
    t("mstatus.wr0",   12'h300, 0, 1, 32'h0,        0, 32'h0,         0);
    t("mstatus.rd0",   12'h300, 1, 0, 32'h0,        1, 32'h0000_1800, 0);
    t("mie.wr",        12'h304, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,         0);
    t("mie.rd",        12'h304, 1, 0, 32'h0,        1, 32'h0000_0080, 0);
    t("mie.wr0",       12'h304, 0, 1, 32'h0,        0, 32'h0,         0);
    t("mepc.wr",       12'h341, 0, 1, 32'h1234_5677, 0, 32'h0,         0);
    t("mepc.rd",       12'h341, 1, 0, 32'h0,        1, 32'h1234_5674, 0);
    t("mcause.wr",     12'h342, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0);
    t("mcause.rd",     12'h342, 1, 0, 32'h0,        1, 32'hDEAD_BEEF, 0);
    t("mtval.wr",      12'h343, 0, 1, 32'h0BAD_F00D, 0, 32'h0,         0);
    t("mtval.rd",      12'h343, 1, 0, 32'h0,        1, 32'h0BAD_F00D, 0);
    t("unsup.7c0",     12'h7C0, 1, 0, 32'h0,        1, 32'h0,         1);
    t("unsup.000",     12'h000, 1, 0, 32'h0,        1, 32'h0,         1);
    t("idle.7c0",      12'h7C0, 0, 0, 32'h0,        1, 32'h0,         0);
    t("mvendorid.rd",  12'hF11, 1, 0, 32'h0,        1, 32'h0,         0);
    t("mhartid.rd",    12'hF14, 1, 0, 32'h0,        1, 32'h0,         0);
    t("mvendorid.wr",  12'hF11, 0, 1, 32'h1,        1, 32'h0,         1);
    t("unsup.f15",     12'hF15, 1, 0, 32'h0,        1, 32'h0,         1);
    t("cycle.wr",      12'hC00, 0, 1, 32'h1,        0, 32'h0,         1);
    t("instreth.wr",   12'hC82, 0, 1, 32'h1,        0, 32'h0,         1);

    repeat (2) step();
    rst = 1'b0;

    chk("rst.trapVector", trapVector, 32'h0);
    chk("rst.mepcOut", mepcOut, 32'h0);
    chk("rst.irqPending", 32'(irqPending), 32'h0);
    rd("rst.mcycle", 12'hB00, 32'h0);
    rd("rst.mstatus", 12'h300, 32'h0000_1800);
    rd("rst.mtvec", 12'h305, 32'h0);

    foreach (tbl[i]) csr_op(tbl[i].nm, tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].wd,
                            tbl[i].ck, tbl[i].er, tbl[i].ei);
    chk("tbl.trapVector", trapVector, 32'hFFFF_FFFC);
    chk("tbl.mepcOut", mepcOut, 32'h1234_5674);

    // Illegal write to the read-only shadow leaves mcycle counting normally.
    wr("cyc.setlo", 12'hB00, 32'h100);
    wr("cyc.sethi", 12'hB80, 32'h0);
    csr_op("cyc.illwr", 12'hC00, 1'b1, 1'b1, 32'hDEAD, 1'b1, 32'h100, 1'b1);
    rd("cyc.after", 12'hC00, 32'h101);
    rd("cyc.hi", 12'hC80, 32'h0);

    // Low-word carry into the high word.
    wr("wrap.setlo", 12'hB00, 32'hFFFF_FFFE);
    wr("wrap.sethi", 12'hB80, 32'h0);
    rd("wrap.lo0", 12'hB00, 32'hFFFF_FFFE);
    rd("wrap.hi0", 12'hB80, 32'h0);
    rd("wrap.lo1", 12'hB00, 32'h0);
    rd("wrap.hi1", 12'hB80, 32'h1);

    // Full 64-bit wrap to zero.
    wr("wrap64.sethi", 12'hB80, 32'hFFFF_FFFF);
    wr("wrap64.setlo", 12'hB00, 32'hFFFF_FFFF);
    rd("wrap64.hi0", 12'hC80, 32'hFFFF_FFFF);
    rd("wrap64.hi1", 12'hC80, 32'h0);
    rd("wrap64.lo", 12'hC00, 32'h1);

    wr("ir.setlo", 12'hB02, 32'h0);
    wr("ir.sethi", 12'hB82, 32'h0);
    retire = 1'b1;
    repeat (5) step();
    retire = 1'b0;
    rd("ir.five", 12'hB02, 32'd5);
    rd("ir.hi", 12'hC82, 32'h0);
    retire = 1'b1;
    wr("ir.supp", 12'hB02, 32'd10);
    retire = 1'b0;
    rd("ir.suppchk", 12'hB02, 32'd10);
    wr("ir.setmax", 12'hB02, 32'hFFFF_FFFF);
    retire = 1'b1;
    step();
    retire = 1'b0;
    rd("ir.carryhi", 12'hB82, 32'h1);
    rd("ir.carrylo", 12'hB02, 32'h0);

    wr("irq.mie", 12'h300, 32'h8);
    wr("irq.mtie", 12'h304, 32'h80);
    timerIrq = 1'b1;
    rd("irq.mip", 12'h344, 32'h80);
    chk("irq.pending", 32'(irqPending), 32'h1);

    // Trap entry drops the coinciding mscratch write.
    trapValid = 1'b1; trapCause = 32'h8000_0007; trapPc = 32'h1002; trapTval = 32'h55;
    csr_op("trap.wrdrop", 12'h340, 1'b1, 1'b1, 32'h1111, 1'b1, 32'hA5A5_5A5A, 1'b0);
    trapValid = 1'b0;
    chk("trap.mepcOut", mepcOut, 32'h1000);
    chk("trap.irqPending", 32'(irqPending), 32'h0);
    rd("trap.mepc", 12'h341, 32'h1000);
    rd("trap.mcause", 12'h342, 32'h8000_0007);
    rd("trap.mtval", 12'h343, 32'h55);
    rd("trap.mstatus", 12'h300, 32'h0000_1880);
    rd("trap.mscratch", 12'h340, 32'hA5A5_5A5A);

    mretValid = 1'b1;
    csr_op("mret.wrdrop", 12'h300, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0000_1880, 1'b0);
    mretValid = 1'b0;
    rd("mret.mstatus", 12'h300, 32'h0000_1888);
    chk("mret.irqPending", 32'(irqPending), 32'h1);

    // Reset wins over a simultaneous trap.
    trapValid = 1'b1; trapCause = 32'h2; trapPc = 32'h2000; trapTval = 32'h77;
    rst = 1'b1;
    repeat (2) step();
    trapValid = 1'b0;
    rst = 1'b0;
    chk("rtrap.irqPending", 32'(irqPending), 32'h0);
    chk("rtrap.trapVector", trapVector, 32'h0);
    chk("rtrap.mepcOut", mepcOut, 32'h0);
    rd("rtrap.mepc", 12'h341, 32'h0);
    rd("rtrap.mcause", 12'h342, 32'h0);
    rd("rtrap.mtval", 12'h343, 32'h0);
    rd("rtrap.mstatus", 12'h300, 32'h0000_1800);
    rd("rtrap.mscratch", 12'h340, 32'h0);
    rd("rtrap.mie", 12'h304, 32'h0);
    rd("rtrap.minstreth", 12'hB82, 32'h0);
    rd("rtrap.minstret", 12'hB02, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
